// File: rtl/hamming_pc_pkg.sv
// Shared constants, codeword field offsets and FSM state type for the
// 64-bit product-code Hamming encoder front end.
package hamming_pc_pkg;

    localparam int DATA_W = 64;
    localparam int ROWS   = 8;
    localparam int H_W    = 8;
    localparam int V_W    = 8;
    localparam int D_W    = 15;
    localparam int CW_W   = 111;

    // LSB positions of each field inside codeword_out
    localparam int CW_DATA_LSB = 47;
    localparam int CW_H_LSB    = 35;
    localparam int CW_V_LSB    = 23;
    localparam int CW_D1_LSB   = 11;
    localparam int CW_D2_LSB   = 0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        ENCODE = 2'd2,
        OUTPUT = 2'd3
    } state_e;

endpackage

// File: rtl/hamming_11_7.sv
// Hamming(11,7) encoder: code bit p-1 holds position p; parity at 1,2,4,8.
module hamming_11_7 (
    input  logic [6:0]  data_i,
    output logic [10:0] code_o
);
    logic p1, p2, p4, p8;

    assign p1 = data_i[0] ^ data_i[1] ^ data_i[3] ^ data_i[4] ^ data_i[6];
    assign p2 = data_i[0] ^ data_i[2] ^ data_i[3] ^ data_i[5] ^ data_i[6];
    assign p4 = data_i[1] ^ data_i[2] ^ data_i[3];
    assign p8 = data_i[4] ^ data_i[5] ^ data_i[6];

    assign code_o = {data_i[6:4], p8, data_i[3:1], p4, data_i[0], p2, p1};
endmodule

// File: rtl/hamming_12_8.sv
// Hamming(12,8) encoder: code bit p-1 holds position p; parity at 1,2,4,8.
module hamming_12_8 (
    input  logic [7:0]  data_i,
    output logic [11:0] code_o
);
    logic p1, p2, p4, p8;

    assign p1 = data_i[0] ^ data_i[1] ^ data_i[3] ^ data_i[4] ^ data_i[6];
    assign p2 = data_i[0] ^ data_i[2] ^ data_i[3] ^ data_i[5] ^ data_i[6];
    assign p4 = data_i[1] ^ data_i[2] ^ data_i[3] ^ data_i[7];
    assign p8 = data_i[4] ^ data_i[5] ^ data_i[6] ^ data_i[7];

    assign code_o = {data_i[7:4], p8, data_i[3:1], p4, data_i[0], p2, p1};
endmodule

// File: rtl/hamming_pc_parity_accum.sv
// Row/column/anti-diagonal parity accumulators, folding ROWS_PER_CYCLE rows
// of the latched word per step.
module hamming_pc_parity_accum
    import hamming_pc_pkg::*;
#(
    parameter int ROWS_PER_CYCLE = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear_i,
    input  logic              step_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [H_W-1:0]    h_o,
    output logic [V_W-1:0]    v_o,
    output logic [D_W-1:0]    d_o,
    output logic              done_o
);
    // With ROWS_PER_CYCLE=8 the step wraps to 0 and the pointer never moves.
    localparam logic [2:0] PTR_STEP = 3'(ROWS_PER_CYCLE);
    localparam logic [2:0] LAST_PTR = 3'(ROWS - ROWS_PER_CYCLE);

    logic [H_W-1:0] h_q, h_d;
    logic [V_W-1:0] v_q, v_d;
    logic [D_W-1:0] d_q, d_d;
    logic [2:0]     row_ptr_q, row_ptr_d;
    logic [ROWS-1:0] row_sel;

    always_comb begin
        for (int r = 0; r < ROWS; r++) begin
            row_sel[r] = (3'(r - (r % ROWS_PER_CYCLE)) == row_ptr_q);
        end
    end

    always_comb begin
        h_d       = h_q;
        v_d       = v_q;
        d_d       = d_q;
        row_ptr_d = row_ptr_q;
        if (clear_i) begin
            h_d       = '0;
            v_d       = '0;
            d_d       = '0;
            row_ptr_d = '0;
        end else if (step_i) begin
            for (int r = 0; r < ROWS; r++) begin
                if (row_sel[r]) begin
                    h_d[r] = ^data_i[8*r +: 8];
                    v_d    = v_d ^ data_i[8*r +: 8];
                    // Bit (r,c) lands on anti-diagonal r+c, stored MSB-first.
                    for (int c = 0; c < 8; c++) begin
                        d_d[14-r-c] = d_d[14-r-c] ^ data_i[8*r+c];
                    end
                end
            end
            row_ptr_d = row_ptr_q + PTR_STEP;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_q       <= '0;
            v_q       <= '0;
            d_q       <= '0;
            row_ptr_q <= '0;
        end else begin
            h_q       <= h_d;
            v_q       <= v_d;
            d_q       <= d_d;
            row_ptr_q <= row_ptr_d;
        end
    end

    assign h_o    = h_q;
    assign v_o    = v_q;
    assign d_o    = d_q;
    assign done_o = (row_ptr_q == LAST_PTR);
endmodule

// File: rtl/hamming_pc_encode_ctrl.sv
// Sequenced product-code Hamming encoder front end: accept one word, fold its
// parities, encode them and hold the 111-bit codeword until taken.
module hamming_pc_encode_ctrl
    import hamming_pc_pkg::*;
#(
    parameter int ROWS_PER_CYCLE = 1,
    parameter int CNT_W          = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] data_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CW_W-1:0]   codeword_out,
    output logic              busy,
    output logic [CNT_W-1:0]  word_cnt,
    output state_e            dbg_state_o
);
    // Handshakes: a transfer happens on a rising edge where valid && ready;
    // valid never depends on ready, and out_valid/codeword_out stay put until taken.
    state_e              state_q, state_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [CW_W-1:0]     cw_q, cw_d;
    logic                out_valid_q, out_valid_d;
    logic                in_ready_q, in_ready_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic                acc_clear, acc_step, acc_done;
    logic [H_W-1:0]      h;
    logic [V_W-1:0]      v;
    logic [D_W-1:0]      d;
    logic [11:0]         h_enc, v_enc, d1_enc;
    logic [10:0]         d2_enc;

    hamming_pc_parity_accum #(.ROWS_PER_CYCLE(ROWS_PER_CYCLE)) u_accum (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear_i (acc_clear),
        .step_i  (acc_step),
        .data_i  (data_q),
        .h_o     (h),
        .v_o     (v),
        .d_o     (d),
        .done_o  (acc_done)
    );

    hamming_12_8 u_enc_h  (.data_i(h),       .code_o(h_enc));
    hamming_12_8 u_enc_v  (.data_i(v),       .code_o(v_enc));
    hamming_12_8 u_enc_d1 (.data_i(d[7:0]),  .code_o(d1_enc));
    hamming_11_7 u_enc_d2 (.data_i(d[14:8]), .code_o(d2_enc));

    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        cw_d        = cw_q;
        out_valid_d = out_valid_q;
        cnt_d       = cnt_q;
        acc_clear   = 1'b0;
        acc_step    = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    data_d    = data_in;
                    acc_clear = 1'b1;
                    state_d   = ACCUM;
                end
            end
            ACCUM: begin
                acc_step = 1'b1;
                if (acc_done) state_d = ENCODE;
            end
            ENCODE: begin
                cw_d        = {data_q, h_enc, v_enc, d1_enc, d2_enc};
                out_valid_d = 1'b1;
                state_d     = OUTPUT;
            end
            OUTPUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    cnt_d       = cnt_q + CNT_W'(1);
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Registered so that ready stays low while reset is asserted.
        in_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            data_q      <= '0;
            cw_q        <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            cw_q        <= cw_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            cnt_q       <= cnt_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign out_valid    = out_valid_q;
    assign codeword_out = cw_q;
    assign busy         = (state_q != IDLE);
    assign word_cnt     = cnt_q;
    assign dbg_state_o  = state_q;
endmodule
